// File: rtl/mem_arbiter.sv
// Two-port CPU/front-panel arbiter for the shared data memory: one-beat strobes, registered read return.
// Define ARB_CPU_PRIO_EN for fixed CPU priority; round-robin otherwise.
module mem_arbiter #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   input  logic              pnl_req,
   input  logic              pnl_we,
   input  logic [ADDR_W-1:0] pnl_addr,
   input  logic [DATA_W-1:0] pnl_wdata,
   output logic              pnl_gnt,
   output logic              pnl_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        owner,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ACC, RWAIT, RCAP} state_t;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_CPU  = 2'b01;
   localparam logic [1:0] OWN_PNL  = 2'b10;

   state_t state;
   logic   win_pnl;
   logic   acc_we;
   logic   pick_pnl;
   logic   pick_we;

`ifndef ARB_CPU_PRIO_EN
   logic   last_pnl;
`endif

   // Winner selection among the requests sampled in IDLE
   always_comb begin
`ifdef ARB_CPU_PRIO_EN
      pick_pnl = pnl_req & ~cpu_req;
`else
      pick_pnl = pnl_req & (~cpu_req | ~last_pnl);
`endif
      pick_we = pick_pnl ? pnl_we : cpu_we;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         win_pnl    <= 1'b0;
         acc_we     <= 1'b0;
         cpu_gnt    <= 1'b0;
         pnl_gnt    <= 1'b0;
         cpu_rvalid <= 1'b0;
         pnl_rvalid <= 1'b0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         rdata      <= '0;
         owner      <= OWN_NONE;
         busy       <= 1'b0;
`ifndef ARB_CPU_PRIO_EN
         last_pnl   <= 1'b1;
`endif
      end else begin
         // Pulses default low every cycle
         cpu_gnt    <= 1'b0;
         pnl_gnt    <= 1'b0;
         cpu_rvalid <= 1'b0;
         pnl_rvalid <= 1'b0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_req || pnl_req) begin
                  state     <= ACC;
                  busy      <= 1'b1;
                  win_pnl   <= pick_pnl;
                  acc_we    <= pick_we;
                  owner     <= pick_pnl ? OWN_PNL : OWN_CPU;
                  mem_addr  <= pick_pnl ? pnl_addr : cpu_addr;
                  mem_wdata <= pick_pnl ? pnl_wdata : cpu_wdata;
                  cpu_gnt   <= ~pick_pnl;
                  pnl_gnt   <= pick_pnl;
                  mem_write <= pick_we;
                  mem_read  <= ~pick_we;
               end
            end
            ACC: begin
`ifndef ARB_CPU_PRIO_EN
               last_pnl <= win_pnl;
`endif
               if (acc_we) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  owner <= OWN_NONE;
               end else begin
                  state <= RWAIT;
               end
            end
            RWAIT: begin
               rdata      <= mem_rdata;
               cpu_rvalid <= ~win_pnl;
               pnl_rvalid <= win_pnl;
               state      <= RCAP;
            end
            RCAP: begin
               state <= IDLE;
               busy  <= 1'b0;
               owner <= OWN_NONE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               owner <= OWN_NONE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-timeline model, directed scenarios and random traffic.
module tb_mem_arbiter;
   localparam int unsigned AW = 16;
   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          pnl_req = 1'b0, pnl_we = 1'b0;
   logic [AW-1:0] pnl_addr = '0;
   logic [DW-1:0] pnl_wdata = '0;
   logic          cpu_gnt, cpu_rvalid, pnl_gnt, pnl_rvalid;
   logic [DW-1:0] rdata;
   logic          mem_read, mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic [1:0]    owner;
   logic          busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
      .pnl_req(pnl_req), .pnl_we(pnl_we), .pnl_addr(pnl_addr), .pnl_wdata(pnl_wdata),
      .pnl_gnt(pnl_gnt), .pnl_rvalid(pnl_rvalid),
      .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .owner(owner), .busy(busy)
   );

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;

   // Expected outputs for one clock cycle
   typedef struct packed {
      logic          cg, pg, cv, pv, rd, wr;
      logic [1:0]    own;
      logic          bsy;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      logic [DW-1:0] rdat;
   } frame_t;

   txn_t   cpu_q[$];
   txn_t   pnl_q[$];
   frame_t sched[$];
   frame_t cur = '0;
   frame_t act;

   function automatic txn_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      txn_t t;
      t.we = we; t.addr = a; t.wdata = d;
      return t;
   endfunction

   function automatic logic [DW-1:0] init_val(input int a);
      return (a == 3) ? 8'h5C : 8'(a * 37 + 11);
   endfunction

   // Memory seen by the DUT: data valid the cycle after mem_read
   bit [DW-1:0] tmem [256];
   bit          twr  [256];
   always @(posedge clk) begin
      if (mem_write) begin
         tmem[mem_addr[7:0]] <= mem_wdata;
         twr[mem_addr[7:0]]  <= 1'b1;
      end
      if (mem_read)
         mem_rdata <= twr[mem_addr[7:0]] ? tmem[mem_addr[7:0]] : init_val(int'(mem_addr[7:0]));
   end

   // Requesters: hold the head transaction until its grant is seen
   always @(negedge clk) begin
      if (cpu_gnt && cpu_q.size() > 0) void'(cpu_q.pop_front());
      if (pnl_gnt && pnl_q.size() > 0) void'(pnl_q.pop_front());
      if (cpu_q.size() > 0) begin
         cpu_req = 1'b1; cpu_we = cpu_q[0].we; cpu_addr = cpu_q[0].addr; cpu_wdata = cpu_q[0].wdata;
      end else begin
         cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      end
      if (pnl_q.size() > 0) begin
         pnl_req = 1'b1; pnl_we = pnl_q[0].we; pnl_addr = pnl_q[0].addr; pnl_wdata = pnl_q[0].wdata;
      end else begin
         pnl_req = 1'b0; pnl_we = 1'b0; pnl_addr = '0; pnl_wdata = '0;
      end
   end

   // Reference model: on each accepted request, lay out the access timeline cycle by cycle
   bit [DW-1:0]   mmem [256];
   bit            mwr  [256];
   bit            m_last_pnl = 1'b1;
   logic          m_pick, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wd;
   frame_t        f;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur = '0;
         sched.delete();
         m_last_pnl = 1'b1;
      end else begin
         if (!cur.bsy && sched.size() == 0 && (cpu_req || pnl_req)) begin
`ifdef ARB_CPU_PRIO_EN
            m_pick = !cpu_req;
`else
            m_pick = (cpu_req && pnl_req) ? !m_last_pnl : pnl_req;
`endif
            m_last_pnl = m_pick;
            m_we   = m_pick ? pnl_we : cpu_we;
            m_addr = m_pick ? pnl_addr : cpu_addr;
            m_wd   = m_pick ? pnl_wdata : cpu_wdata;
            f = cur;
            f.bsy = 1'b1; f.own = m_pick ? 2'b10 : 2'b01;
            f.cg = !m_pick; f.pg = m_pick; f.cv = 1'b0; f.pv = 1'b0;
            f.rd = !m_we; f.wr = m_we; f.addr = m_addr; f.wd = m_wd;
            sched.push_back(f);
            if (m_we) begin
               mmem[m_addr[7:0]] = m_wd;
               mwr[m_addr[7:0]]  = 1'b1;
            end else begin
               f.cg = 1'b0; f.pg = 1'b0; f.rd = 1'b0;
               sched.push_back(f);
               f.rdat = mwr[m_addr[7:0]] ? mmem[m_addr[7:0]] : init_val(int'(m_addr[7:0]));
               f.cv = !m_pick; f.pv = m_pick;
               sched.push_back(f);
            end
         end
         if (sched.size() > 0) begin
            cur = sched.pop_front();
         end else begin
            cur.cg = 1'b0; cur.pg = 1'b0; cur.cv = 1'b0; cur.pv = 1'b0;
            cur.rd = 1'b0; cur.wr = 1'b0; cur.own = 2'b00; cur.bsy = 1'b0;
         end
      end
   end

   // Every cycle out of reset, all outputs must match the model
   always @(negedge clk) begin
      if (rst) begin
         act = frame_t'({cpu_gnt, pnl_gnt, cpu_rvalid, pnl_rvalid, mem_read, mem_write,
                         owner, busy, mem_addr, mem_wdata, rdata});
         total++;
         if (act !== cur) begin
            bad++;
            $display("FAIL cycle_check t=%0t got=%h want=%h", $time, act, cur);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s t=%0t got=%h want=%h", nm, $time, a, e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [1:0] exp_g;
   int         g;
   int         n;

   initial begin
      // Reset state, checked while reset is held
      repeat (3) step();
      chk("rst_ctrl", 32'({cpu_gnt, pnl_gnt, cpu_rvalid, pnl_rvalid, mem_read, mem_write, busy, owner}), 32'h0);
      chk("rst_data", 32'({mem_addr, mem_wdata, rdata}), 32'h0);
      #2 rst = 1'b1;

      // Single CPU write
      step();
      cpu_q.push_back(mk(1'b1, 16'h0010, 8'hA5));
      step();
      chk("cpu_wr_gnt", 32'({cpu_gnt, mem_write, mem_read, pnl_gnt}), 32'b1100);
      chk("cpu_wr_addr", 32'(mem_addr), 32'h0010);
      chk("cpu_wr_data", 32'(mem_wdata), 32'hA5);
      chk("cpu_wr_owner", 32'(owner), 32'h1);
      step(); step();

      // Panel read of 0x0003 returning 0x5C
      pnl_q.push_back(mk(1'b0, 16'h0003, 8'h00));
      step();
      chk("pnl_rd_gnt", 32'({pnl_gnt, mem_read, owner}), 32'b1110);
      chk("pnl_rd_addr", 32'(mem_addr), 32'h0003);
      step();
      chk("pnl_rd_wait", 32'({pnl_rvalid, cpu_rvalid, busy}), 32'b001);
      step();
      chk("pnl_rd_valid", 32'({pnl_rvalid, cpu_rvalid}), 32'b10);
      chk("pnl_rd_data", 32'(rdata), 32'h5C);
      step();

      // Ten idle cycles: nothing moves, rdata holds
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle", 32'({busy, owner, mem_read, mem_write, cpu_gnt, pnl_gnt, rdata}), 32'h5C);
      end

      // CPU request arriving during a panel read waits for the read to finish
      pnl_q.push_back(mk(1'b0, 16'h0040, 8'h00));
      step();
      chk("rw_pnl_gnt", 32'(pnl_gnt), 32'h1);
      step();
      cpu_q.push_back(mk(1'b1, 16'h0041, 8'h77));
      step();
      chk("rw_rcap", 32'({pnl_rvalid, cpu_gnt, mem_read, mem_write}), 32'b1000);
      step();
      chk("rw_idle", 32'({busy, cpu_gnt}), 32'b00);
      step();
      chk("rw_cpu_gnt", 32'({cpu_gnt, mem_write, mem_read}), 32'b110);
      chk("rw_cpu_addr", 32'(mem_addr), 32'h0041);
      step(); step();

      // Reset during the access cycle of a CPU read
      cpu_q.push_back(mk(1'b0, 16'h0005, 8'h00));
      @(posedge clk);
      #2;
      chk("abort_pre", 32'({cpu_gnt, mem_read, busy}), 32'b111);
      rst = 1'b0;
      #1;
      chk("abort_drop", 32'({cpu_gnt, mem_read, busy, cpu_rvalid}), 32'b0000);
      #1;
      pnl_q.push_back(mk(1'b1, 16'h0006, 8'h99));
      step(); step();
      #2 rst = 1'b1;
      step();
      chk("abort_regnt", 32'({cpu_gnt, pnl_gnt, mem_read, owner}), 32'b10101);
      repeat (10) step();

      // Back-to-back writes from both sides after a fresh reset
      @(posedge clk);
      #2 rst = 1'b0;
      step();
      #2 rst = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         cpu_q.push_back(mk(1'b1, 16'(16'h0020 + i), 8'(8'h10 + i)));
         pnl_q.push_back(mk(1'b1, 16'(16'h0030 + i), 8'(8'h20 + i)));
      end
      for (int i = 1; i <= 12; i++) begin
         step();
         g = (i - 1) / 2;
`ifdef ARB_CPU_PRIO_EN
         exp_g = (i % 2 == 0) ? 2'b00 : ((g < 3) ? 2'b10 : 2'b01);
`else
         exp_g = (i % 2 == 0) ? 2'b00 : ((g % 2 == 0) ? 2'b10 : 2'b01);
`endif
         chk("grant_order", 32'({cpu_gnt, pnl_gnt}), 32'(exp_g));
      end

      // Random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         step();
         if ($urandom_range(0, 3) == 0 && cpu_q.size() < 2)
            cpu_q.push_back(mk(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom)));
         if ($urandom_range(0, 3) == 0 && pnl_q.size() < 2)
            pnl_q.push_back(mk(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom)));
      end

      n = 0;
      while ((cpu_q.size() > 0 || pnl_q.size() > 0) && n < 200) begin
         step();
         n++;
      end
      chk("drain", 32'(cpu_q.size() + pnl_q.size()), 32'h0);
      repeat (5) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
